// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits.
// Latency: the start bit appears on tx_out the cycle after the transfer edge; the frame lasts div*(bits) cycles.
// Backpressure: tx_ready is high only in IDLE; one byte is accepted per tx_valid && tx_ready edge.
module uart_tx_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Frame state and per-frame latched configuration.
  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic                stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                two_stop_q, two_stop_d;
  logic                tx_out_q, tx_out_d;
  logic                done_q, done_d;

  // Helper decodes.
  logic                xfer;
  logic                bit_end;
  logic [DIV_W-1:0]    div_in;

  // Handshake, divisor sanitising and end-of-bit detection.
  always_comb begin
    xfer    = tx_valid && (state_q == IDLE);
    div_in  = (baud_div == '0) ? DIV_W'(1) : baud_div;
    // div_q is at least 1 whenever a frame is running, so div_q-1 never underflows there.
    bit_end = (cnt_q == (div_q - DIV_W'(1)));
  end

  // Next-state logic: walks START -> DATA -> [PARITY] -> STOP and steps the baud/bit/stop counters.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          // Everything that shapes the frame is captured here so later config writes cannot disturb it.
          data_d     = tx_data;
          div_d      = div_in;
          par_en_d   = parity_en;
          par_bit_d  = (^tx_data) ^ parity_odd;
          two_stop_d = two_stop;
          cnt_d      = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == LAST_IDX) begin
            stop_idx_d = 1'b0;
            state_d    = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_d      = '0;
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            // The done flop rises together with the return to IDLE, so the pulse lands on the first idle cycle.
            stop_idx_d = 1'b0;
            state_d    = IDLE;
            done_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line value for the next cycle, decoded from next state so tx_out is a clean flop output aligned to the state.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      IDLE:    tx_out_d = 1'b1;
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = data_d[bit_idx_d];
      PARITY:  tx_out_d = par_bit_d;
      STOP:    tx_out_d = 1'b1;
      default: tx_out_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and forces the line idle-high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_out_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_out_q   <= tx_out_d;
      done_q     <= done_d;
    end
  end

  // Outputs come straight from flops or from state decode.
  always_comb begin
    tx_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    tx_out   = tx_out_q;
    done     = done_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: hand-written line sequences checked cycle by cycle.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
// All checks go through chk(); summary line reports errors and total checks.
module tb_uart_tx_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_out;
  logic        busy;
  logic        done;

  int n_chk;
  int n_err;

  uart_tx_ctrl #(.DATA_W(8), .DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: presents a byte and config, checks ready, then drops valid after the transfer edge.
  task automatic send(input logic [7:0] d, input logic [15:0] div, input logic pen,
                      input logic podd, input logic two);
    baud_div   = div;
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = two;
    tx_data    = d;
    tx_valid   = 1'b1;
    chk("ready_before_send", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Called at the falling edge of the first frame cycle; exp lists line bits in transmit order.
  // Ends at the falling edge of the first idle cycle after the frame.
  task automatic run_frame(input string tag, input string exp, input int div);
    byte ch;
    for (int b = 0; b < exp.len(); b++) begin
      ch = exp[b];
      for (int c = 0; c < div; c++) begin
        chk({tag, "_line"}, tx_out, (ch == "1") ? 1 : 0);
        chk({tag, "_done_low"}, done, 0);
        if (c == 0) begin
          chk({tag, "_busy"}, busy, 1);
          chk({tag, "_ready_low"}, tx_ready, 0);
        end
        @(negedge clk);
      end
    end
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_end_idle_line"}, tx_out, 1);
    chk({tag, "_end_ready"}, tx_ready, 1);
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    baud_div   = 16'd0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    // Idle with no valid for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_tx_out", tx_out, 1);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end

    // 0x55, div 4, even parity (four ones -> 0), one stop: 44 cycles, done on cycle 45.
    send(8'h55, 16'd4, 1'b1, 1'b0, 1'b0);
    run_frame("f55e", "01010101001", 4);
    @(negedge clk);
    chk("f55e_done_one_cycle", done, 0);

    // 0x55 with odd parity -> parity bit 1.
    send(8'h55, 16'd4, 1'b1, 1'b1, 1'b0);
    run_frame("f55o", "01010101011", 4);
    @(negedge clk);
    chk("f55o_done_one_cycle", done, 0);

    // 0x07 even parity: three ones -> parity bit 1.
    send(8'h07, 16'd4, 1'b1, 1'b0, 1'b0);
    run_frame("f07e", "01110000011", 4);
    @(negedge clk);
    chk("f07e_done_one_cycle", done, 0);

    // 0xA3, divisor 0 treated as 1, no parity, two stop bits: 11 cycles.
    send(8'hA3, 16'd0, 1'b0, 1'b0, 1'b1);
    run_frame("fa3", "01100010111", 1);
    @(negedge clk);
    chk("fa3_done_one_cycle", done, 0);

    // Back-to-back with valid held: 0x01 at div 2, then 0x80; div changed to 8 mid-frame.
    baud_div   = 16'd2;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    tx_data    = 8'h01;
    tx_valid   = 1'b1;
    chk("b2b_ready_first", tx_ready, 1);
    @(negedge clk);
    baud_div = 16'd8;
    tx_data  = 8'h80;
    run_frame("b2b1", "0100000001", 2);
    // The second byte transfers at the end of this single idle cycle.
    @(negedge clk);
    tx_valid = 1'b0;
    run_frame("b2b2", "0000000011", 8);
    @(negedge clk);
    chk("b2b2_done_one_cycle", done, 0);

    // Reset during data bit 3 of 0x55 (bit 3 = 0), div 4, no parity.
    send(8'h55, 16'd4, 1'b0, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    chk("pre_rst_line_bit3", tx_out, 0);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_line_async", tx_out, 1);
    chk("in_rst_ready", tx_ready, 1);
    chk("in_rst_busy", busy, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("in_rst_line", tx_out, 1);
      chk("in_rst_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("post_rst_line", tx_out, 1);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    // Clean frame after the abort: 0xFF, even parity (eight ones -> 0).
    send(8'hFF, 16'd4, 1'b1, 1'b0, 1'b0);
    run_frame("fff", "01111111101", 4);
    @(negedge clk);
    chk("fff_done_one_cycle", done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side frame sequencer for the UART.
- Accepts one byte per valid/ready handshake and serialises it as start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits.
- Owns the baud-period counter and the bit counter.
- Computes the parity bit internally: XOR-reduce the latched byte, inverted when odd parity is selected.
- Sits between the TX byte source (FIFO or CPU register) and the serial pin.

Parameters:
- DATA_W, 8, data bits per frame.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- baud_div  input  DIV_W  clock cycles per bit; 0 is treated as 1.
- parity_en  input  1  1 = insert parity bit.
- parity_odd  input  1  1 = odd parity (inverted XOR), 0 = even.
- two_stop  input  1  1 = two stop bits, 0 = one.
- tx_valid  input  1  byte available from source.
- tx_data  input  DATA_W  byte to send.
- tx_ready  output  1  controller can accept a byte.
- tx_out  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, tx_out=1, tx_ready=1, busy=0, done=0, all counters 0.
- Reset mid-frame aborts the frame immediately; tx_out returns to 1 asynchronously.
- Handshake:
  - Transfer occurs on a rising edge with tx_valid && tx_ready.
  - tx_ready=1 only in IDLE.
  - tx_data, baud_div (0 mapped to 1), parity_en, parity_odd and two_stop are latched at the transfer edge.
  - Config changes during a frame have no effect on that frame.
- Parity bit = (^data_latched) ^ parity_odd. Computed at latch time, held for the frame.
- States and transitions:
  - IDLE: tx_out=1. On transfer -> START.
  - START: tx_out=0 for div cycles -> DATA.
  - DATA: tx_out=data_latched[bit_idx], bit_idx 0..DATA_W-1, each held div cycles. After bit DATA_W-1 -> PARITY if parity_en_latched, else -> STOP.
  - PARITY: tx_out=parity bit for div cycles -> STOP.
  - STOP: tx_out=1 for div cycles (2*div if two_stop_latched) -> IDLE.
- Baud counter:
  - Counts 0..div-1 within each bit, resets to 0 on each bit boundary.
  - Never wraps past div-1.
  - Stop counter tracks stop-bit index 0..1.
- Timing:
  - First start-bit cycle is the cycle after the transfer edge.
  - Frame length = div*(1+DATA_W+parity_en+1+two_stop) cycles.
- done: asserted for exactly one cycle, the first IDLE cycle after STOP completes. tx_ready is also 1 in that cycle.
- busy = (state != IDLE).
- Back-to-back: if tx_valid is held, the next byte is accepted in the first IDLE cycle. Exactly one idle-high cycle separates consecutive frames.
- tx_out is registered (glitch-free); all outputs come from flops or state decode only.

Test Plan:
- Reset, then idle with tx_valid=0 for 20 cycles -> tx_out=1, tx_ready=1, busy=0, done never asserted.
- baud_div=4, parity_en=1, parity_odd=0, two_stop=0, send 0x55 -> line sequence 0,1,0,1,0,1,0,1,0,0(parity),1. Each bit lasts 4 cycles, 44 cycles total. done pulses on cycle 45 after the transfer edge.
- Same byte 0x55 with parity_odd=1 -> parity bit=1. Then 0x07 with parity_odd=0 -> parity bit=1 (three ones).
- baud_div=0, parity_en=0, two_stop=1, send 0xA3 -> div treated as 1: 0,1,1,0,0,0,1,0,1,1,1. Frame is 11 cycles; tx_ready stays low throughout.
- tx_valid held high with 0x01 then 0x80, baud_div=2 -> second start bit begins exactly one idle cycle after the first done pulse. Changing baud_div to 8 mid-frame does not alter the first frame's timing.
- Assert rst_n=0 during DATA bit 3, release after 2 cycles -> tx_out=1 while in reset, state IDLE, no done pulse. Then a new byte 0xFF sends cleanly.
